// File: rtl/cgra_sched_pkg.sv
// Shared types and width helpers for the CGRA thread-ID scheduler.
package cgra_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DISPATCH,
    S_DRAIN,
    S_DONE
  } sched_state_e;

  function automatic int tid_width(input int total_tid);
    return (total_tid > 1) ? $clog2(total_tid) : 1;
  endfunction

  function automatic int credit_width(input int max_inflight);
    return $clog2(max_inflight + 1);
  endfunction

endpackage

// File: rtl/tid_xyz_counter.sv
// Cascaded x/y/z wrap counter with a flat thread id; holds at the last thread.
module tid_xyz_counter #(
  parameter int TW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_step,
  input  logic [TW-1:0] i_lim_x,
  input  logic [TW-1:0] i_lim_y,
  input  logic [TW-1:0] i_lim_z,
  output logic [TW-1:0] o_tid,
  output logic [TW-1:0] o_x,
  output logic [TW-1:0] o_y,
  output logic [TW-1:0] o_z,
  output logic          o_last
);

  logic [TW-1:0] r_tid, r_x, r_y, r_z;
  logic          w_x_wrap, w_y_wrap;

  assign w_x_wrap = (r_x == i_lim_x);
  assign w_y_wrap = (r_y == i_lim_y);
  assign o_last   = w_x_wrap & w_y_wrap & (r_z == i_lim_z);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tid <= '0;
      r_x   <= '0;
      r_y   <= '0;
      r_z   <= '0;
    end else if (i_clr) begin
      r_tid <= '0;
      r_x   <= '0;
      r_y   <= '0;
      r_z   <= '0;
    end else if (i_step && !o_last) begin
      r_tid <= r_tid + TW'(1);
      if (w_x_wrap) begin
        r_x <= '0;
        if (w_y_wrap) begin
          r_y <= '0;
          r_z <= r_z + TW'(1);
        end else begin
          r_y <= r_y + TW'(1);
        end
      end else begin
        r_x <= r_x + TW'(1);
      end
    end
  end

  assign o_tid = r_tid;
  assign o_x   = r_x;
  assign o_y   = r_y;
  assign o_z   = r_z;

endmodule

// File: rtl/cgra_tid_scheduler.sv
// Dispatches kernel thread IDs into the CGRA under a credit limit and tracks retirement.
module cgra_tid_scheduler
  import cgra_sched_pkg::*;
#(
  parameter  int TOTAL_TID    = 512,
  parameter  int MAX_INFLIGHT = 16,
  localparam int TW           = tid_width(TOTAL_TID),
  localparam int CW           = credit_width(MAX_INFLIGHT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          clr,
  input  logic [TW-1:0] ntid_x,
  input  logic [TW-1:0] ntid_y,
  input  logic [TW-1:0] ntid_z,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [TW-1:0] out_tid,
  output logic [TW-1:0] out_tid_x,
  output logic [TW-1:0] out_tid_y,
  output logic [TW-1:0] out_tid_z,
  input  logic          retire_valid,
  output logic [CW-1:0] inflight,
  output logic          busy,
  output logic          done,
  output logic          err
);

  // Each factor needs TW+1 bits, so the product is sized to never wrap.
  localparam int PW = 3 * (TW + 1);

  sched_state_e  r_state, w_state_nxt;
  logic [TW-1:0] r_ntid_x, r_ntid_y, r_ntid_z;
  logic [CW-1:0] r_inflight;
  logic          r_err;
  logic [PW-1:0] w_total;
  logic          w_oversize, w_launch, w_fire, w_last, w_underflow;

  assign w_total = (PW'(ntid_x) + PW'(1)) * (PW'(ntid_y) + PW'(1)) * (PW'(ntid_z) + PW'(1));
  assign w_oversize  = (w_total > PW'(TOTAL_TID));
  assign w_launch    = start & ~clr & ((r_state == S_IDLE) | (r_state == S_DONE));
  assign out_valid   = (r_state == S_DISPATCH) && (r_inflight < CW'(MAX_INFLIGHT));
  assign w_fire      = out_valid & out_ready;
  assign w_underflow = retire_valid & ~w_fire & (r_inflight == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = (r_state == S_DISPATCH) || (r_state == S_DRAIN);
    done        = (r_state == S_DONE);
    if (clr) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: if (start) w_state_nxt = w_oversize ? S_DONE : S_DISPATCH;
        S_DISPATCH:     if (w_fire && w_last) w_state_nxt = S_DRAIN;
        S_DRAIN:        if (r_inflight == '0) w_state_nxt = S_DONE;
        default:        w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ntid_x   <= '0;
      r_ntid_y   <= '0;
      r_ntid_z   <= '0;
      r_inflight <= '0;
      r_err      <= 1'b0;
    end else if (clr) begin
      r_inflight <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_launch) begin
        r_ntid_x <= ntid_x;
        r_ntid_y <= ntid_y;
        r_ntid_z <= ntid_z;
      end
      case ({w_fire, retire_valid})
        2'b10:   r_inflight <= r_inflight + CW'(1);
        2'b01:   if (r_inflight != '0) r_inflight <= r_inflight - CW'(1);
        default: r_inflight <= r_inflight;
      endcase
      if (w_launch)         r_err <= w_oversize | w_underflow;
      else if (w_underflow) r_err <= 1'b1;
    end
  end

  tid_xyz_counter #(.TW(TW)) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (clr | w_launch),
    .i_step  (w_fire),
    .i_lim_x (r_ntid_x),
    .i_lim_y (r_ntid_y),
    .i_lim_z (r_ntid_z),
    .o_tid   (out_tid),
    .o_x     (out_tid_x),
    .o_y     (out_tid_y),
    .o_z     (out_tid_z),
    .o_last  (w_last)
  );

  assign inflight = r_inflight;
  assign err      = r_err;

endmodule
